// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit -- RV32I instruction fetch: PC, imem address, IF/ID register, redirect/halt.
// Rev 1.0

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_valid,
    output logic        o_misaligned,
    output logic [15:0] o_redirect_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;

    assign pc_next_seq = pc + 32'd4;
    assign o_imem_addr = pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= RUN;
            pc               <= RESET_PC;
            o_instr          <= NOP_INSTR;
            o_pc             <= 32'd0;
            o_pc_four        <= 32'd0;
            o_valid          <= 1'b0;
            o_misaligned     <= 1'b0;
            o_redirect_count <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    if (i_redirect) begin
                        // The IF/ID entry is on the wrong path either way, so it is squashed.
                        o_instr   <= NOP_INSTR;
                        o_pc      <= 32'd0;
                        o_pc_four <= 32'd0;
                        o_valid   <= 1'b0;
                        if (i_redirect_pc[1:0] != 2'b00) begin
                            state        <= HALT;
                            o_misaligned <= 1'b1;
                        end else begin
                            pc <= i_redirect_pc;
                            if (o_redirect_count != 16'hFFFF) begin
                                o_redirect_count <= o_redirect_count + 16'd1;
                            end
                        end
                    end else if (!i_stall) begin
                        o_instr   <= i_imem_rdata;
                        o_pc      <= pc;
                        o_pc_four <= pc_next_seq;
                        o_valid   <= 1'b1;
                        pc        <= pc_next_seq;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the five-stage non-forwarding RV32I pipeline. It owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register for the decoder. It also acts on the branch/jump redirect (pc_sel plus target) that the control path produces in EX, inserting a bubble and halting on a misaligned target.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: encoding driven on o_instr for bubbles (addi x0,x0,0).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hazard-unit stall; holds PC and IF/ID.
- i_redirect  in  1  branch taken or jump in EX (the pc_sel signal).
- i_redirect_pc  in  32  redirect target (ALU result from EX).
- o_imem_addr  out  32  instruction memory byte address (= PC register).
- i_imem_rdata  in  32  instruction word at o_imem_addr; combinational memory, valid in the same cycle.
- o_instr  out  32  IF/ID instruction.
- o_pc  out  32  IF/ID PC of o_instr.
- o_pc_four  out  32  IF/ID o_pc + 4.
- o_valid  out  1  IF/ID entry holds a real instruction.
- o_misaligned  out  1  sticky; a redirect target had bits [1:0] != 0.
- o_redirect_count  out  16  number of accepted redirects, saturating.

## Operation

- State machine: RUN, HALT. Reset enters RUN.
- Per-edge priority in RUN: i_reset > i_redirect > i_stall > advance.
- Advance (no redirect, no stall):
  - IF/ID takes {i_imem_rdata, pc, pc+4, valid=1}.
  - pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0; o_pc_four is likewise computed mod 2^32.
- Stall (i_stall=1, i_redirect=0): pc, IF/ID, o_valid and counters all hold.
- Redirect with an aligned target (i_redirect=1, i_redirect_pc[1:0]==0):
  - pc <= i_redirect_pc.
  - IF/ID becomes a bubble: o_instr=NOP_INSTR, o_pc=0, o_pc_four=0, o_valid=0.
  - o_redirect_count increments, saturating at 16'hFFFF.
  - Redirect wins over a simultaneous stall, because the instruction in IF/ID is on the wrong path.
- Redirect with a misaligned target (i_redirect_pc[1:0]!=0):
  - Go to HALT and set o_misaligned=1.
  - pc keeps its current value; IF/ID becomes a bubble; the counter does not increment.
- HALT:
  - pc is frozen and IF/ID holds the bubble (o_valid=0).
  - i_redirect and i_stall are ignored.
  - Only i_reset leaves HALT.
- The block performs no decode of i_imem_rdata. An all-zero or illegal word is passed through with o_valid=1; the decoder flags it.

## Timing

- Reset values after a reset edge:
  - pc=RESET_PC, so o_imem_addr=RESET_PC.
  - o_instr=NOP_INSTR, o_pc=0, o_pc_four=0, o_valid=0.
  - o_misaligned=0, o_redirect_count=0, state=RUN.
- Reset mid-operation (during a stall, a redirect or HALT) overrides everything at that edge.
- o_imem_addr comes straight from the PC register; no combinational path from any input.
- Fetch latency: a word presented at o_imem_addr=A in cycle N appears on o_instr, with o_pc=A and o_valid=1, in cycle N+1, provided edge N is not stalled or redirected.
- Redirect sampled at edge N:
  - cycle N+1: o_imem_addr=target, o_valid=0.
  - cycle N+2: o_instr=mem[target], o_valid=1 (absent a stall).
  - Exactly one bubble per redirect.
- Back-to-back redirects on consecutive edges: the last target wins, each aligned one counts, and o_valid stays 0 throughout.
- Once the stall is released, advance resumes on the next edge; no instruction is lost or duplicated.

## Test plan

- Reset with RESET_PC=0 and memory returning word(addr)=addr|0x13 -> o_imem_addr=0, o_valid=0; the next edges give o_pc=0,4,8 with o_instr=0x13,0x17,0x1B and o_valid=1.
- Stall asserted for 3 cycles while o_pc=8 -> o_pc stays 8 and o_imem_addr stays 12 for 3 cycles; the next edge gives o_pc=12.
- i_redirect=1 with i_redirect_pc=0x100 while i_stall=1 -> next cycle: o_imem_addr=0x100, o_valid=0, o_instr=0x13, o_redirect_count=1; the following cycle: o_pc=0x100, o_valid=1.
- Redirect to 0x102 -> o_misaligned=1 and o_valid=0; later redirects to 0x200 are ignored and o_imem_addr stays frozen; i_reset restores RUN with PC=RESET_PC and o_misaligned=0.
- RESET_PC=32'hFFFF_FFF8, free-running -> o_pc=FFFF_FFF8, FFFF_FFFC, 0000_0000; o_pc_four=0 when o_pc=FFFF_FFFC.
- 65,537 aligned redirects -> o_redirect_count reaches 16'hFFFF and holds there.
